// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI streamer: FSM states, default command header
// and a frame-length helper.
package dac_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_LDAC  = 3'd4
    } state_t;

    localparam logic [3:0] CMD_WORD_DEFAULT = 4'b0011;

    // System clock cycles from IDLE exit to IDLE re-entry for one frame.
    function automatic int frame_cycles(input int frame_width, input int clk_div);
        return (2 * frame_width + 3) * clk_div;
    endfunction

endpackage

// File: rtl/dac_spi_tick.sv
// Half-period tick generator for the DAC SPI streamer: CLK_DIV down-counter with
// synchronous clear; tick fires on the last cycle of every half-period.
module dac_spi_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || (cnt_q == '0)) begin
            cnt_d = CNT_TOP;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign tick = !clr && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_TOP;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_streamer.sv
// Serialises buffered DAC codes to an SPI DAC (mode 0, MSB first) and strobes LDAC_N.
// Optional build macro DAC_SPI_SIGNED_IN_EN: DATA_IN is two's complement, converted to offset binary.
module dac_spi_streamer
    import dac_spi_pkg::*;
#(
    parameter int                   DATA_WIDTH  = 12,
    parameter int                   FRAME_WIDTH = 16,
    parameter int                   CMD_WIDTH   = 4,
    parameter logic [CMD_WIDTH-1:0] CMD_WORD    = CMD_WIDTH'(CMD_WORD_DEFAULT),
    parameter int                   CLK_DIV     = 4
) (
    input  logic                  CLK_SYS,
    input  logic                  nRST,
    input  logic                  EN,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  DATA_VALID,
    output logic                  READY,
    output logic                  OVERRUN,
    output logic                  BUSY,
    output logic                  SCLK,
    output logic                  MOSI,
    output logic                  CS_N,
    output logic                  LDAC_N
);

    localparam int HC_W = $clog2(2 * FRAME_WIDTH) + 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(2 * FRAME_WIDTH - 1);

    state_t                 state_q, state_d;
    logic [HC_W-1:0]        hcnt_q, hcnt_d;
    logic [FRAME_WIDTH-1:0] sreg_q, sreg_d;
    logic [DATA_WIDTH-1:0]  buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic                   ready_q, ready_d;
    logic                   ovr_q, ovr_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;
    logic                   cs_n_q, cs_n_d;
    logic                   ldac_n_q, ldac_n_d;
    logic                   busy_q, busy_d;

    logic                   half_tick;
    logic                   wr_en;
    logic                   consume;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic [FRAME_WIDTH-1:0] frame_word;

`ifdef DAC_SPI_SIGNED_IN_EN
    assign wr_data = {~DATA_IN[DATA_WIDTH-1], DATA_IN[DATA_WIDTH-2:0]};
`else
    assign wr_data = DATA_IN;
`endif

    // Divider is held cleared in IDLE so every frame starts on a full half-period.
    dac_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (CLK_SYS),
        .rst_n (nRST),
        .clr   (state_q == ST_IDLE),
        .tick  (half_tick)
    );

    always_comb begin
        frame_word = '0;
        frame_word[FRAME_WIDTH-1 -: CMD_WIDTH]              = CMD_WORD;
        frame_word[FRAME_WIDTH-1-CMD_WIDTH -: DATA_WIDTH]   = buf_q;
    end

    always_comb begin
        wr_en      = DATA_VALID && ready_q;
        consume    = (state_q == ST_IDLE) && buf_full_q && EN;
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        sreg_d     = sreg_q;
        buf_d      = wr_en ? wr_data : buf_q;
        buf_full_d = wr_en || (buf_full_q && !consume);

        case (state_q)
            ST_IDLE: begin
                if (consume) begin
                    state_d = ST_LOAD;
                    sreg_d  = frame_word;
                    hcnt_d  = '0;
                end
            end
            ST_LOAD: begin
                if (half_tick) begin
                    state_d = ST_SHIFT;
                    hcnt_d  = '0;
                end
            end
            ST_SHIFT: begin
                if (half_tick) begin
                    if (hcnt_q == HC_LAST) begin
                        state_d = ST_HOLD;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                    // Advance the data after the SCLK-high half so MOSI changes on the falling edge.
                    if (!hcnt_q[0]) begin
                        sreg_d = {sreg_q[FRAME_WIDTH-2:0], 1'b0};
                    end
                end
            end
            ST_HOLD: begin
                if (half_tick) begin
                    state_d = ST_LDAC;
                end
            end
            ST_LDAC: begin
                if (half_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pin values are decoded from next state so they are registered and glitch-free.
        ready_d  = EN && !buf_full_d;
        ovr_d    = DATA_VALID && !ready_q;
        sclk_d   = (state_d == ST_SHIFT) && !hcnt_d[0];
        mosi_d   = ((state_d == ST_LOAD) || (state_d == ST_SHIFT)) ? sreg_d[FRAME_WIDTH-1] : 1'b0;
        cs_n_d   = !((state_d == ST_LOAD) || (state_d == ST_SHIFT));
        ldac_n_d = (state_d != ST_LDAC);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            hcnt_q     <= '0;
            buf_full_q <= 1'b0;
            ready_q    <= 1'b0;
            ovr_q      <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            ldac_n_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            buf_full_q <= buf_full_d;
            ready_q    <= ready_d;
            ovr_q      <= ovr_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            ldac_n_q   <= ldac_n_d;
            busy_q     <= busy_d;
        end
    end

    // Payload registers carry no reset; they are only observed under valid control state.
    always_ff @(posedge CLK_SYS) begin
        sreg_q <= sreg_d;
        buf_q  <= buf_d;
    end

    assign READY   = ready_q;
    assign OVERRUN = ovr_q;
    assign BUSY    = busy_q;
    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;
    assign CS_N    = cs_n_q;
    assign LDAC_N  = ldac_n_q;

endmodule

// File: tb/tb_dac_spi_streamer.sv
// Scoreboard bench for dac_spi_streamer: accepted samples queue expected SPI frames,
// a negedge monitor reassembles frames from the pins and checks timing envelopes.
`timescale 1ns/1ps
module tb_dac_spi_streamer;

    localparam int DW       = 12;
    localparam int FW       = 16;
    localparam int CW       = 4;
    localparam int DIV      = 4;
    localparam logic [CW-1:0] CMD = 4'b0011;
    localparam int EXP_BUSY = (2 * FW + 3) * DIV;
    localparam int EXP_CS   = (2 * FW + 1) * DIV;
    localparam int EXP_LDAC = DIV;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          en = 1'b0;
    logic          dvalid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          ready, overrun, busy, sclk, mosi, cs_n, ldac_n;

    int checks = 0;
    int errors = 0;
    int frames_done = 0;
    int ovr_pulses = 0;
    logic [FW-1:0] exp_q[$];
    int gap_q[$];
    logic [FW-1:0] last_word = '0;

    always #5 clk = ~clk;

    dac_spi_streamer dut (
        .CLK_SYS    (clk),
        .nRST       (nrst),
        .EN         (en),
        .DATA_IN    (din),
        .DATA_VALID (dvalid),
        .READY      (ready),
        .OVERRUN    (overrun),
        .BUSY       (busy),
        .SCLK       (sclk),
        .MOSI       (mosi),
        .CS_N       (cs_n),
        .LDAC_N     (ldac_n)
    );

    function automatic logic [FW-1:0] model_frame(input logic [DW-1:0] d);
        logic [DW-1:0] code;
        logic [FW-1:0] w;
        code = d;
`ifdef DAC_SPI_SIGNED_IN_EN
        code = d + DW'(1 << (DW - 1));
`endif
        w = FW'({CMD, code});
        return w << (FW - CW - DW);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic          prev_sclk = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0, prev_ldac = 1'b1;
    logic          exp_ovr = 1'b0;
    int            bits = 0, cs_len = 0, busy_len = 0, ldac_len = 0, idle_len = 0;
    logic [FW-1:0] shreg = '0;

    always @(negedge clk) begin
        if (!nrst) begin
            prev_sclk = 1'b0; prev_cs = 1'b1; prev_busy = 1'b0; prev_ldac = 1'b1;
            exp_ovr = 1'b0; bits = 0; cs_len = 0; busy_len = 0; ldac_len = 0; idle_len = 0;
        end else begin
            check("overrun", overrun, exp_ovr);
            if (overrun) ovr_pulses++;
            exp_ovr = dvalid && !ready;
            if (dvalid && ready) exp_q.push_back(model_frame(din));

            if (!cs_n) begin
                if (prev_cs) begin
                    bits = 0;
                    cs_len = 0;
                end
                cs_len++;
                if (sclk && !prev_sclk) begin
                    shreg = {shreg[FW-2:0], mosi};
                    bits++;
                end
            end else begin
                check("idle_pins", {sclk, mosi}, 2'b00);
                if (!prev_cs) begin
                    check("frame_bits", bits, FW);
                    check("cs_low_cycles", cs_len, EXP_CS);
                    last_word = shreg;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got %0h expected no frame", shreg);
                    end else begin
                        check("frame_word", shreg, exp_q.pop_front());
                    end
                end
            end

            if (!ldac_n) begin
                ldac_len++;
                check("ldac_while_cs_high", cs_n, 1'b1);
            end else if (!prev_ldac) begin
                check("ldac_low_cycles", ldac_len, EXP_LDAC);
                ldac_len = 0;
            end

            if (busy) begin
                if (!prev_busy) begin
                    gap_q.push_back(idle_len);
                    idle_len = 0;
                end
                busy_len++;
            end else begin
                if (prev_busy) begin
                    check("busy_cycles", busy_len, EXP_BUSY);
                    frames_done++;
                    busy_len = 0;
                end
                idle_len++;
            end

            prev_sclk = sclk;
            prev_cs   = cs_n;
            prev_busy = busy;
            prev_ldac = ldac_n;
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        while (!ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready_timeout", ready, 1'b1);
        din = d;
        dvalid = 1'b1;
        @(posedge clk); #1;
        dvalid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input string name);
        int n = 0;
        while ((frames_done < target || busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, frames_done, target);
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, busy, 1'b1);
    endtask

    initial begin
        #600us;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int o0;
        int rises;
        logic ps;
        logic [DW-1:0] a, b, c;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {ready, overrun, busy, sclk, mosi, cs_n, ldac_n}, 7'b0000011);
        nrst = 1'b1;
        @(posedge clk); #1;
        check("ready_before_en", ready, 1'b0);
        en = 1'b1;
        @(posedge clk); #1;
        check("ready_after_en", ready, 1'b1);

        // Single frame
        send(12'hA5C);
        wait_frames(1, "single_frame");
`ifdef DAC_SPI_SIGNED_IN_EN
        check("single_word", last_word, 16'h325C);
`else
        check("single_word", last_word, 16'h3A5C);
`endif
        check("single_idle", {busy, ready}, 2'b01);

        // Back-to-back
        gap_q.delete();
        f0 = frames_done;
        o0 = ovr_pulses;
        send(DW'($urandom)); send(DW'($urandom)); send(DW'($urandom));
        wait_frames(f0 + 3, "b2b_frames");
        check("b2b_no_overrun", ovr_pulses, o0);
        check("b2b_gap_count", gap_q.size(), 3);
        if (gap_q.size() >= 3) begin
            check("b2b_gap2", gap_q[1], 1);
            check("b2b_gap3", gap_q[2], 1);
        end

        // Queue one, drop one
        f0 = frames_done;
        o0 = ovr_pulses;
        a = DW'($urandom); b = DW'($urandom); c = ~b;
        send(a);
        wait_busy("q_busy");
        send(b);
        check("q_ready_full", ready, 1'b0);
        din = c;
        dvalid = 1'b1;
        @(posedge clk); #1;
        dvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("q_overrun_pulses", ovr_pulses, o0 + 1);
        wait_frames(f0 + 2, "q_frames");
        check("q_second_word", last_word, model_frame(b));
        repeat (300) @(posedge clk);
        #1;
        check("q_no_third", frames_done, f0 + 2);

        // Reset at SCLK edge 7
        send(DW'($urandom));
        rises = 0;
        ps = sclk;
        for (int i = 0; i < 400 && rises < 7; i++) begin
            @(posedge clk); #1;
            if (sclk && !ps) rises++;
            ps = sclk;
        end
        check("rst_edge7_reached", rises, 7);
        nrst = 1'b0;
        #1;
        check("rst_async_pins", {cs_n, sclk, ldac_n, busy, ready}, 5'b10100);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        nrst = 1'b1;
        f0 = frames_done;
        repeat (300) @(posedge clk);
        #1;
        check("rst_no_resume", {frames_done == f0, busy}, 2'b10);
        check("rst_ready", ready, 1'b1);
        send(DW'($urandom));
        wait_frames(f0 + 1, "rst_new_frame");

        // EN low with sample buffered
        f0 = frames_done;
        send(DW'($urandom));
        wait_busy("en_busy");
        send(DW'($urandom));
        repeat (20) @(posedge clk);
        #1;
        en = 1'b0;
        wait_frames(f0 + 1, "en_frame_finishes");
        repeat (200) @(posedge clk);
        #1;
        check("en_low_hold", {frames_done == f0 + 1, busy, ready}, 3'b100);
        en = 1'b1;
        wait_frames(f0 + 2, "en_resume");
        check("en_queue_empty", exp_q.size(), 0);

`ifdef DAC_SPI_SIGNED_IN_EN
        send(12'h000);
        wait_frames(frames_done + 1, "signed_min");
        check("signed_zero_word", last_word, 16'h3800);
        send(12'h800);
        wait_frames(frames_done + 1, "signed_neg");
        check("signed_neg_word", last_word, 16'h3000);
`endif

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 19) != 0);
            dvalid = ($urandom_range(0, 5) == 0);
            din = DW'($urandom);
            @(posedge clk); #1;
        end
        dvalid = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || busy); i++) begin
            @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        #1;
        check("rand_drain", {exp_q.size() == 0, busy}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
